// File: rtl/spmv_stager_pkg.sv
// Shared types and constants for the SpMV bitonic input stager.
// Provides the stager FSM encoding, the reserved sentinel row index and the network depth helper.
package spmv_stager_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Truncated to BITS_ROW_IDX at the point of use; all-ones sorts last ascending.
    localparam logic [63:0] SENTINEL_ROW_IDX = '1;

    function automatic int unsigned net_latency(input int unsigned lsw);
        return (lsw * (lsw + 1)) / 2;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Enable-gated shift register that tracks vector validity through the sorting network.
// busy reports any valid vector still in flight.
module valid_delay_line #(
    parameter int unsigned DEPTH = 4
)(
    input  logic clk,
    input  logic rst_b,
    input  logic enable,
    input  logic din,
    output logic dout,
    output logic busy
);

    logic [DEPTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            pipe <= '0;
        end else if (enable) begin
            pipe <= {pipe[DEPTH-2:0], din};
        end
    end

    assign dout = pipe[DEPTH-1];
    assign busy = |pipe;

endmodule

// File: rtl/bitonic_input_stager.sv
// Gathers one element per stream into a lane vector for the bitonic sorting network,
// tagging lanes with stream ids, padding finished lanes with sentinels and tracking validity.
module bitonic_input_stager
    import spmv_stager_pkg::*;
#(
    parameter  int unsigned LOG_STREAM_WIDTH = 2,
    parameter  int unsigned BITS_ROW_IDX     = 8,
    parameter  int unsigned DATA_PRECISION   = 8,
    localparam int unsigned STREAM_WIDTH     = 1 << LOG_STREAM_WIDTH,
    localparam int unsigned DATA_WIDTH       = BITS_ROW_IDX + DATA_PRECISION + LOG_STREAM_WIDTH
)(
    input  logic                                   clk,
    input  logic                                   rst_b,
    input  logic                                   start,
    input  logic [STREAM_WIDTH-1:0]                in_valid,
    input  logic [STREAM_WIDTH-1:0]                in_last,
    input  logic [STREAM_WIDTH*BITS_ROW_IDX-1:0]   in_row_idx,
    input  logic [STREAM_WIDTH*DATA_PRECISION-1:0] in_value,
    output logic [STREAM_WIDTH-1:0]                in_ready,
    input  logic                                   out_ready,
    output logic                                   net_enable,
    output logic [STREAM_WIDTH*DATA_WIDTH-1:0]     net_din,
    output logic                                   net_dout_valid,
    output logic                                   batch_done,
    output logic [15:0]                            vec_count
);

    localparam int unsigned NET_LATENCY = net_latency(LOG_STREAM_WIDTH);
    localparam logic [BITS_ROW_IDX-1:0] SENTINEL_ROW = SENTINEL_ROW_IDX[BITS_ROW_IDX-1:0];

    state_t                          state;
    logic [STREAM_WIDTH-1:0]         lane_done;
    logic [STREAM_WIDTH-1:0]         done_next;
    logic [STREAM_WIDTH*DATA_WIDTH-1:0] issue_vec;
    logic                            issue_ok;
    logic                            pipe_busy;

    assign net_enable = out_ready;
    assign issue_ok   = (state == GATHER) && out_ready
                        && (&(in_valid | lane_done)) && !(&lane_done);
    assign in_ready   = {STREAM_WIDTH{issue_ok}} & in_valid & ~lane_done;
    assign batch_done = (state == DONE);

    // Every lane not yet done is valid whenever issue_ok holds, so in_last needs no extra qualifier.
    always_comb begin
        issue_vec = '0;
        done_next = lane_done;
        for (int unsigned i = 0; i < STREAM_WIDTH; i++) begin
            if (lane_done[i]) begin
                issue_vec[i*DATA_WIDTH +: DATA_WIDTH] =
                    {SENTINEL_ROW, {DATA_PRECISION{1'b0}}, LOG_STREAM_WIDTH'(i)};
            end else begin
                issue_vec[i*DATA_WIDTH +: DATA_WIDTH] =
                    {in_row_idx[i*BITS_ROW_IDX +: BITS_ROW_IDX],
                     in_value[i*DATA_PRECISION +: DATA_PRECISION],
                     LOG_STREAM_WIDTH'(i)};
                if (in_last[i]) begin
                    done_next[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= GATHER;
                GATHER:  if (&lane_done) state <= DRAIN;
                DRAIN:   if (!pipe_busy) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            lane_done <= '0;
            vec_count <= '0;
            net_din   <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                lane_done <= '0;
                vec_count <= '0;
            end
        end else if (issue_ok) begin
            lane_done <= done_next;
            net_din   <= issue_vec;
            if (vec_count != 16'hFFFF) begin
                vec_count <= vec_count + 16'd1;
            end
        end
    end

    valid_delay_line #(
        .DEPTH (NET_LATENCY + 1)
    ) u_valid_delay_line (
        .clk    (clk),
        .rst_b  (rst_b),
        .enable (net_enable),
        .din    (issue_ok),
        .dout   (net_dout_valid),
        .busy   (pipe_busy)
    );

endmodule
